// File: rtl/aes_host_pkg.sv
// Shared types and defaults for the AES capture host sequencer.
package aes_host_pkg;

  localparam int unsigned BLK_W           = 128;
  localparam int unsigned AES_TIMEOUT_DEF = 1023;
  localparam int unsigned TRIG_MIN_DEF    = 16;
  localparam int unsigned BUSY_WAIT_DEF   = 63;

  typedef enum logic [2:0] {
    WAIT_KEY = 3'd0,
    WAIT_PT  = 3'd1,
    START    = 3'd2,
    RUN      = 3'd3,
    SEND     = 3'd4,
    WAIT_HI  = 3'd5,
    WAIT_LO  = 3'd6
  } state_e;

endpackage

// File: rtl/trig_stretch.sv
// Scope trigger: set rises it, clear drops it once it has been high TRIG_MIN cycles.
module trig_stretch #(
  parameter int unsigned TRIG_MIN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic trigger_o
);

  localparam int unsigned CW = $clog2(TRIG_MIN + 1);

  logic          trig_q, trig_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] hold_q, hold_d;

  // hold_q counts high cycles including the current one; an early clear is remembered in pend_q
  always_comb begin
    trig_d = trig_q;
    pend_d = pend_q;
    hold_d = hold_q;
    if (set_i) begin
      trig_d = 1'b1;
      pend_d = 1'b0;
      hold_d = CW'(1);
    end else if (trig_q) begin
      if (hold_q != CW'(TRIG_MIN)) hold_d = hold_q + CW'(1);
      if ((clr_i || pend_q) && (hold_q >= CW'(TRIG_MIN))) begin
        trig_d = 1'b0;
        pend_d = 1'b0;
      end else if (clr_i) begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q <= 1'b0;
      pend_q <= 1'b0;
      hold_q <= '0;
    end else begin
      trig_q <= trig_d;
      pend_q <= pend_d;
      hold_q <= hold_d;
    end
  end

  assign trigger_o = trig_q;

endmodule

// File: rtl/aes_host_ctrl.sv
// Sequencer between the hex-ASCII UART and the AES-128 core: key load, encrypt, return ciphertext.
module aes_host_ctrl
  import aes_host_pkg::*;
#(
  parameter int unsigned AES_TIMEOUT = AES_TIMEOUT_DEF,
  parameter int unsigned TRIG_MIN    = TRIG_MIN_DEF,
  parameter int unsigned BUSY_WAIT   = BUSY_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rekey,
  input  logic             rx_ack,
  input  logic [BLK_W-1:0] rx_data,
  input  logic             tx_busy,
  output logic             tx_cmd,
  output logic [BLK_W-1:0] tx_data,
  output logic [BLK_W-1:0] aes_key,
  output logic [BLK_W-1:0] aes_pt,
  output logic             aes_start,
  input  logic             aes_done,
  input  logic [BLK_W-1:0] aes_ct,
  output logic             trigger,
  output logic             key_valid,
  output logic             err_timeout,
  output logic             overrun,
  output logic [2:0]       state_dbg
);

  localparam int unsigned AW = $clog2(AES_TIMEOUT + 1);
  localparam int unsigned BW = $clog2(BUSY_WAIT + 1);

  state_e           state_q, state_d;
  logic [BLK_W-1:0] key_q, key_d, pt_q, pt_d, txd_q, txd_d;
  logic             kv_q, kv_d, err_q, err_d, ovr_q, ovr_d;
  logic             start_q, start_d, txcmd_q, txcmd_d;
  logic [AW-1:0]    acnt_q, acnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             trig_set, trig_clr;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    pt_d     = pt_q;
    txd_d    = txd_q;
    kv_d     = kv_q;
    err_d    = err_q;
    ovr_d    = ovr_q;
    start_d  = 1'b0;
    txcmd_d  = 1'b0;
    acnt_d   = acnt_q;
    bcnt_d   = bcnt_q;
    trig_set = 1'b0;
    trig_clr = 1'b0;
    unique case (state_q)
      WAIT_KEY: if (rx_ack) begin
        key_d   = rx_data;
        kv_d    = 1'b1;
        state_d = WAIT_PT;
      end
      WAIT_PT: if (rekey) begin
        kv_d    = 1'b0;
        state_d = WAIT_KEY;
      end else if (rx_ack) begin
        // start pulse and trigger are registered on entry so both are high during START
        pt_d     = rx_data;
        start_d  = 1'b1;
        trig_set = 1'b1;
        state_d  = START;
      end
      START: begin
        acnt_d  = AW'(1);
        state_d = RUN;
      end
      RUN: if (aes_done) begin
        txd_d    = aes_ct;
        trig_clr = 1'b1;
        state_d  = SEND;
      end else if (acnt_q == AW'(AES_TIMEOUT - 1)) begin
        err_d    = 1'b1;
        txd_d    = '0;
        trig_clr = 1'b1;
        state_d  = WAIT_PT;
      end else if (acnt_q != AW'(AES_TIMEOUT)) begin
        acnt_d = acnt_q + AW'(1);
      end
      SEND: if (!tx_busy) begin
        txcmd_d = 1'b1;
        bcnt_d  = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: if (tx_busy) begin
        state_d = WAIT_LO;
      end else if (bcnt_q >= BW'(BUSY_WAIT - 1)) begin
        state_d = SEND;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
      WAIT_LO: if (!tx_busy) state_d = WAIT_PT;
      default: state_d = WAIT_KEY;
    endcase
    if (rx_ack && !(state_q inside {WAIT_KEY, WAIT_PT})) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_KEY;
      key_q   <= '0;
      pt_q    <= '0;
      txd_q   <= '0;
      kv_q    <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      start_q <= 1'b0;
      txcmd_q <= 1'b0;
      acnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      txd_q   <= txd_d;
      kv_q    <= kv_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      start_q <= start_d;
      txcmd_q <= txcmd_d;
      acnt_q  <= acnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  trig_stretch #(
    .TRIG_MIN(TRIG_MIN)
  ) u_trig (
    .clk       (clk),
    .rst       (rst),
    .set_i     (trig_set),
    .clr_i     (trig_clr),
    .trigger_o (trigger)
  );

  assign tx_cmd      = txcmd_q;
  assign tx_data     = txd_q;
  assign aes_key     = key_q;
  assign aes_pt      = pt_q;
  assign aes_start   = start_q;
  assign key_valid   = kv_q;
  assign err_timeout = err_q;
  assign overrun     = ovr_q;
  assign state_dbg   = state_q;

endmodule
